// File: rtl/vb_pkg.sv
// Shared constants, FSM state type and round-robin pick helper for the VB stream arbiter.
package vb_pkg;
  localparam int GW   = 7;
  localparam int MARK = 7;
  localparam int NREQ = 4;
  localparam int G4W  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // First requesting index strictly after ptr, wrapping; ptr itself is checked last.
  function automatic logic [1:0] rr_pick(input logic [NREQ-1:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = ptr;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = ptr + i[1:0];
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction
endpackage

// File: rtl/vb_group_core.sv
// Holds the granted value and walks its 7-bit groups from the highest non-zero one down to G0.
module vb_group_core
  import vb_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          advance,
  input  logic [31:0]   value,
  output logic [GW-1:0] group,
  output logic          last
);
  logic [31:0] value_r;
  logic [2:0]  idx_r;
  logic [2:0]  first_s;

  // Highest non-zero group of the incoming value; G0 when the value is all zero.
  always_comb begin
    if (value[31:28] != 4'd0) begin
      first_s = 3'd4;
    end else if (value[27:21] != 7'd0) begin
      first_s = 3'd3;
    end else if (value[20:14] != 7'd0) begin
      first_s = 3'd2;
    end else if (value[13:7] != 7'd0) begin
      first_s = 3'd1;
    end else begin
      first_s = 3'd0;
    end
  end

  // Value and group index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_r <= 32'd0;
      idx_r   <= 3'd0;
    end else if (load) begin
      value_r <= value;
      idx_r   <= first_s;
    end else if (advance && (idx_r != 3'd0)) begin
      idx_r <= idx_r - 3'd1;
    end
  end

  // Group currently selected by the index.
  always_comb begin
    case (idx_r)
      3'd4:    group = {3'd0, value_r[31:32-G4W]};
      3'd3:    group = value_r[27:21];
      3'd2:    group = value_r[20:14];
      3'd1:    group = value_r[13:7];
      default: group = value_r[6:0];
    endcase
  end

  assign last = (idx_r == 3'd0);
endmodule

// File: rtl/vb_stream_arbiter.sv
// Round-robin arbiter sharing one VB encoder among four requesters; emits one tagged byte per cycle.
module vb_stream_arbiter
  import vb_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NREQ-1:0]      REQ,
  input  logic [32*NREQ-1:0]   DATA,
  output logic [7:0]           STREAM,
  output logic                 VALID,
  output logic [1:0]           SRC,
  output logic                 LAST,
  output logic [NREQ-1:0]      ACK,
  output logic                 BUSY
);
  state_t        state_r;
  logic [1:0]    ptr_r;
  logic [1:0]    win_r;
  logic [1:0]    pick_s;
  logic [31:0]   win_data_s;
  logic          load_s;
  logic          advance_s;
  logic [GW-1:0] group_s;
  logic          last_s;
  logic [7:0]    byte_s;

  assign pick_s     = rr_pick(REQ, ptr_r);
  assign win_data_s = DATA[32*pick_s +: 32];
  assign load_s     = (state_r == IDLE) && (REQ != 4'd0);
  assign advance_s  = (state_r == SEND);

  // Continuation bit clear on interior bytes, set on the terminating G0 byte.
  always_comb begin
    byte_s       = {1'b0, group_s};
    byte_s[MARK] = last_s;
  end

  vb_group_core u_core (
    .clk     (CLK),
    .rst     (RST),
    .load    (load_s),
    .advance (advance_s),
    .value   (win_data_s),
    .group   (group_s),
    .last    (last_s)
  );

  // Arbitration FSM and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
      ptr_r   <= 2'd3;
      win_r   <= 2'd0;
      STREAM  <= 8'h00;
      VALID   <= 1'b0;
      SRC     <= 2'd0;
      LAST    <= 1'b0;
      ACK     <= 4'd0;
      BUSY    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          VALID <= 1'b0;
          LAST  <= 1'b0;
          ACK   <= 4'd0;
          if (load_s) begin
            win_r   <= pick_s;
            BUSY    <= 1'b1;
            state_r <= SEND;
          end else begin
            BUSY <= 1'b0;
          end
        end
        SEND: begin
          STREAM <= byte_s;
          VALID  <= 1'b1;
          SRC    <= win_r;
          if (last_s) begin
            LAST    <= 1'b1;
            ACK     <= 4'd1 << win_r;
            ptr_r   <= win_r;
            state_r <= IDLE;
          end else begin
            LAST <= 1'b0;
            ACK  <= 4'd0;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/vb_stream_arbiter.md
# vb_stream_arbiter

Round-robin arbiter and sequencer that shares one variable-byte (VB) encoding datapath between four requesters, each presenting a 32-bit unsigned value. It grants one requester at a time, latches that requester's value, and emits the VB byte stream most-significant group first, one byte per cycle, tagged with the source index. It sits between the requesters and the downstream byte sink, and owns all sequencing of the encoder.

## Interface
- NREQ, 4: number of requesters; fixed at 4, not a free parameter.
- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous, active-high reset
- REQ  in  4  level request, bit i = requester i
- DATA  in  128  requester i value at DATA[32*i+31 : 32*i]
- STREAM  out  8  encoded byte
- VALID  out  1  STREAM carries a byte this cycle
- SRC  out  2  index of the requester owning STREAM
- LAST  out  1  current byte is the terminating byte
- ACK  out  4  one-hot pulse, asserted with requester i's terminating byte
- BUSY  out  1  a transaction is in progress

## Operation
- Encoding: the value is split into groups G4=bits[31:28] (4 bits), then G3=[27:21], G2=[20:14], G1=[13:7], G0=[6:0] (7 bits each).
- Leading all-zero groups are skipped. Emission starts at the highest non-zero group; G0 is always emitted.
- Interior zero groups after the first emitted group are emitted as 0x00.
- Non-final bytes are {0, group}. The final byte is {1, G0}. Value 0 encodes as the single byte 0x80.
- Bytes per value: 1..5.
- FSM has two states, IDLE and SEND.
- IDLE with REQ≠0: select the winner round-robin, starting at the index after the last granted one. After reset the last granted index is 3, so requester 0 has top priority. Latch the winner's DATA and its index, compute the first group index, go to SEND.
- SEND: emit one byte per cycle. On the final byte assert LAST and ACK[winner], update the last-granted pointer, and return to IDLE.
- DATA and REQ of the winner must stay stable until ACK. DATA is sampled only at grant.
- Requesters that are not granted keep waiting, with no timeout.
- The requester drops REQ in the ACK cycle. A REQ still high at the following edge is treated as a new request, and other pending requesters win first.

## Timing
- Reset values: STREAM=0x00, VALID=0, SRC=0, LAST=0, ACK=0, BUSY=0, FSM=IDLE, pointer=3.
- All outputs are registered.
- Edge k: IDLE samples REQ≠0 and grants; BUSY=1 from edge k.
- Edges k+1..k+n: byte j is driven with VALID=1, where n = byte count. LAST and ACK are high only after edge k+n.
- Edge k+n+1: VALID, LAST and ACK clear; BUSY=0. The FSM is IDLE from edge k+n and may grant at edge k+n+1.
- This gives a minimum of 1 bubble cycle between streams.
- Latency from request to first byte: 2 edges when idle.
- Reset mid-stream: asynchronous clear to reset values. The transaction is dropped with no ACK, and the pointer resets.
- A REQ bit dropping during SEND is ignored. Arbitration happens only in IDLE.

## Structure
- Package vb_pkg holds:
  - group width 7
  - MARK bit index 7
  - NREQ=4
  - G4 width 4
  - FSM state enum
- One sub-module, vb_group_core. It contains the 32-bit value register, the 3-bit group index, and the first-non-zero-group logic. It has load/advance inputs and group/last outputs.
- The arbiter keeps the round-robin pointer, the FSM and the output registers.

## Test plan
- REQ=0001, DATA0=0x00000005 -> one byte 0x85, LAST=1, ACK=0001, SRC=0.
- REQ=0010, DATA1=0x12345678 -> bytes 0x01,0x11,0x51,0x2C,0xF8 on 5 consecutive cycles, SRC=1, ACK on 0xF8.
- DATA0=0x00200000 -> 0x01,0x00,0x00,0x80 (interior zeros kept). DATA0=0 -> 0x80. DATA0=0xFFFFFFFF -> 0x0F,0x7F,0x7F,0x7F,0xFF.
- REQ=1111 held, each dropped on its ACK -> grant order 0,1,2,3, 1-cycle VALID gap between streams. Then REQ0 held high after ACK while REQ2 is asserted -> 2 served before 0.
- RST pulse during byte 3 of a 5-byte stream -> all outputs are 0 immediately, no ACK. Next REQ=0100 is served first, with byte 1 two edges after the request.
